// File: rtl/shk_pkg.sv
// Shared types and constants for the shake bus arbiter.
package shk_pkg;

   localparam int unsigned WD_SHK_SYNC_DEF = 16;
   localparam int unsigned WD_SHK_DLAY_DEF = 15;

   // Wide enough for any sync width; truncated to WD_SHK_SYNC at the use site.
   localparam logic [63:0] SHK_TOUT_SMISO = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } shk_state_e;

endpackage

// File: rtl/shk_rr_pick.sv
// Combinational round-robin picker: first request at or after last_grant+1, wrapping.
module shk_rr_pick #(
   parameter int unsigned N_PORT = 4
) (
   input  logic [N_PORT-1:0]         req,
   input  logic [$clog2(N_PORT)-1:0] last_grant,
   output logic                      pick_vld,
   output logic [$clog2(N_PORT)-1:0] pick_id
);

   localparam int unsigned WD_ID = $clog2(N_PORT);

   logic [WD_ID-1:0] idx;

   always_comb begin
      pick_vld = 1'b0;
      pick_id  = '0;
      idx      = '0;
      for (int unsigned k = 1; k <= N_PORT; k++) begin
         idx = WD_ID'((32'(last_grant) + k) % N_PORT);
         if (!pick_vld && req[idx]) begin
            pick_vld = 1'b1;
            pick_id  = idx;
         end
      end
   end

endmodule

// File: rtl/shk_arb.sv
// N-to-1 round-robin shake arbiter with registered forwarding, response return
// to the winner only, and a BUSY timeout that answers with an error response.
module shk_arb
   import shk_pkg::*;
#(
   parameter int unsigned WD_SHK_SYNC = WD_SHK_SYNC_DEF,
   parameter int unsigned WD_SHK_DLAY = WD_SHK_DLAY_DEF,
   parameter int unsigned N_PORT      = 4,
   parameter int unsigned TOUT_CYC    = 1024
) (
   input  logic                            i_sys_clk,
   input  logic                            i_sys_resetn,
   input  logic [N_PORT-1:0]               s_shk_wvalid,
   input  logic [N_PORT*WD_SHK_SYNC-1:0]   s_shk_smosi,
   input  logic [N_PORT*WD_SHK_DLAY-1:0]   s_shk_dmosi,
   output logic [N_PORT-1:0]               s_shk_wready,
   output logic [WD_SHK_SYNC-1:0]          s_shk_smiso,
   output logic [WD_SHK_DLAY-1:0]          s_shk_dmiso,
   output logic                            m_shk_wvalid,
   output logic [WD_SHK_SYNC-1:0]          m_shk_smosi,
   output logic [WD_SHK_DLAY-1:0]          m_shk_dmosi,
   input  logic                            m_shk_wready,
   input  logic [WD_SHK_SYNC-1:0]          m_shk_smiso,
   input  logic [WD_SHK_DLAY-1:0]          m_shk_dmiso,
   output logic                            o_tout_pulse,
   output logic [$clog2(N_PORT)-1:0]       o_grant_id
);

   localparam int unsigned WD_ID  = $clog2(N_PORT);
   localparam int unsigned WD_CNT = $clog2(TOUT_CYC);
   localparam logic [WD_CNT-1:0] CNT_LAST = WD_CNT'(TOUT_CYC - 1);

   shk_state_e        state, state_nxt;
   logic [WD_ID-1:0]  last_grant;
   logic [WD_CNT-1:0] tout_cnt;
   logic              pick_vld;
   logic [WD_ID-1:0]  pick_id;
   logic              grant_ld, ack_ld, tout_ld;

   shk_rr_pick #(.N_PORT(N_PORT)) u_pick (
      .req        (s_shk_wvalid),
      .last_grant (last_grant),
      .pick_vld   (pick_vld),
      .pick_id    (pick_id)
   );

   always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
      if (!i_sys_resetn) state <= IDLE;
      else               state <= state_nxt;
   end

   // A downstream ack on the terminal-count cycle takes precedence over the timeout.
   always_comb begin
      state_nxt = state;
      grant_ld  = 1'b0;
      ack_ld    = 1'b0;
      tout_ld   = 1'b0;
      case (state)
         IDLE: begin
            if (pick_vld) begin
               grant_ld  = 1'b1;
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            if (m_shk_wready) begin
               ack_ld    = 1'b1;
               state_nxt = RESP;
            end else if (tout_cnt == CNT_LAST) begin
               tout_ld   = 1'b1;
               state_nxt = RESP;
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
      if (!i_sys_resetn) begin
         last_grant   <= WD_ID'(N_PORT - 1);
         tout_cnt     <= '0;
         o_grant_id   <= '0;
         m_shk_wvalid <= 1'b0;
         m_shk_smosi  <= '0;
         m_shk_dmosi  <= '0;
         s_shk_wready <= '0;
         s_shk_smiso  <= '0;
         s_shk_dmiso  <= '0;
         o_tout_pulse <= 1'b0;
      end else begin
         s_shk_wready <= '0;
         o_tout_pulse <= 1'b0;
         if (grant_ld) begin
            o_grant_id   <= pick_id;
            m_shk_wvalid <= 1'b1;
            m_shk_smosi  <= s_shk_smosi[pick_id*WD_SHK_SYNC +: WD_SHK_SYNC];
            m_shk_dmosi  <= s_shk_dmosi[pick_id*WD_SHK_DLAY +: WD_SHK_DLAY];
         end
         if (state == BUSY) tout_cnt <= tout_cnt + WD_CNT'(1);
         if (ack_ld || tout_ld) begin
            m_shk_wvalid <= 1'b0;
            s_shk_wready <= N_PORT'(1) << o_grant_id;
            o_tout_pulse <= tout_ld;
            s_shk_smiso  <= ack_ld ? m_shk_smiso : WD_SHK_SYNC'(SHK_TOUT_SMISO);
            s_shk_dmiso  <= ack_ld ? m_shk_dmiso : '0;
         end
         if (state == RESP) begin
            last_grant <= o_grant_id;
            tout_cnt   <= '0;
         end
      end
   end

endmodule

// File: tb/tb_shk_arb.sv
// Directed self-checking bench for shk_arb (4 ports, TOUT_CYC=8).
module tb_shk_arb;

   localparam int unsigned WS = 16;
   localparam int unsigned WDL = 15;
   localparam int unsigned NP = 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [NP-1:0]   s_wvalid = '0;
   logic [NP*WS-1:0]  s_smosi = '0;
   logic [NP*WDL-1:0] s_dmosi = '0;
   logic [NP-1:0]   s_wready;
   logic [WS-1:0]   s_smiso;
   logic [WDL-1:0]  s_dmiso;
   logic            m_wvalid;
   logic [WS-1:0]   m_smosi;
   logic [WDL-1:0]  m_dmosi;
   logic            m_wready = 1'b0;
   logic [WS-1:0]   slv_smiso = '0;
   logic [WDL-1:0]  slv_dmiso = '0;
   logic            tout;
   logic [1:0]      grant;

   int checks = 0;
   int passed = 0;
   int ack_delay = 0;
   int busy_cnt = 0;

   shk_arb #(.WD_SHK_SYNC(WS), .WD_SHK_DLAY(WDL), .N_PORT(NP), .TOUT_CYC(8)) dut (
      .i_sys_clk    (clk),
      .i_sys_resetn (rst_n),
      .s_shk_wvalid (s_wvalid),
      .s_shk_smosi  (s_smosi),
      .s_shk_dmosi  (s_dmosi),
      .s_shk_wready (s_wready),
      .s_shk_smiso  (s_smiso),
      .s_shk_dmiso  (s_dmiso),
      .m_shk_wvalid (m_wvalid),
      .m_shk_smosi  (m_smosi),
      .m_shk_dmosi  (m_dmosi),
      .m_shk_wready (m_wready),
      .m_shk_smiso  (slv_smiso),
      .m_shk_dmiso  (slv_dmiso),
      .o_tout_pulse (tout),
      .o_grant_id   (grant)
   );

   always #5 clk = ~clk;

   // Downstream slave model: acks on the ack_delay-th BUSY cycle (0 = first).
   always @(negedge clk) begin
      if (m_wvalid) begin
         m_wready = (busy_cnt == ack_delay);
         busy_cnt = busy_cnt + 1;
      end else begin
         m_wready = 1'b0;
         busy_cnt = 0;
      end
   end

   task automatic set_port(input int p, input logic [WS-1:0] sm, input logic [WDL-1:0] dm);
      s_smosi[p*WS +: WS]   = sm;
      s_dmosi[p*WDL +: WDL] = dm;
   endtask

   // Bounded wait for the response cycle; counts downstream-valid cycles on the way.
   task automatic wait_resp(output logic [NP-1:0] wr, output int hi, output logic tseen);
      wr = '0;
      hi = 0;
      tseen = 1'b0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (m_wvalid) hi++;
         if (tout) tseen = 1'b1;
         if (s_wready != '0) begin
            wr = s_wready;
            return;
         end
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      s_wvalid = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (m_wvalid !== 1'b0) $display("FAIL reset_m_wvalid got %b exp 0", m_wvalid); else passed++;
      checks++; if (s_wready !== 4'b0) $display("FAIL reset_s_wready got %b exp 0000", s_wready); else passed++;
      checks++; if ({s_smiso, s_dmiso, m_smosi, m_dmosi} !== '0)
         $display("FAIL reset_data got %h %h %h %h exp 0", s_smiso, s_dmiso, m_smosi, m_dmosi); else passed++;
      checks++; if ({tout, grant} !== 3'b0) $display("FAIL reset_tout_grant got %b %0d exp 0 0", tout, grant); else passed++;
   endtask

   task automatic test_single();
      logic [NP-1:0] wr; int hi; logic ts;
      ack_delay = 1;
      slv_smiso = 16'hA5A5;
      slv_dmiso = 15'h0ABC;
      @(posedge clk); #1;
      set_port(2, 16'h0004, 15'h0123);
      s_wvalid = 4'b0100;
      @(posedge clk);
      @(negedge clk);
      checks++; if (m_wvalid !== 1'b1) $display("FAIL single_m_wvalid got %b exp 1", m_wvalid); else passed++;
      checks++; if (m_smosi !== 16'h0004 || m_dmosi !== 15'h0123)
         $display("FAIL single_m_data got %h %h exp 0004 0123", m_smosi, m_dmosi); else passed++;
      checks++; if (grant !== 2'd2) $display("FAIL single_grant got %0d exp 2", grant); else passed++;
      wait_resp(wr, hi, ts);
      checks++; if (wr !== 4'b0100) $display("FAIL single_wready got %b exp 0100", wr); else passed++;
      checks++; if (s_smiso !== 16'hA5A5 || s_dmiso !== 15'h0ABC)
         $display("FAIL single_resp got %h %h exp a5a5 0abc", s_smiso, s_dmiso); else passed++;
      checks++; if (ts !== 1'b0) $display("FAIL single_tout got %b exp 0", ts); else passed++;
      @(posedge clk); #1;
      s_wvalid = '0;
      @(negedge clk);
      checks++; if (s_wready !== 4'b0 || m_wvalid !== 1'b0)
         $display("FAIL single_after got %b %b exp 0000 0", s_wready, m_wvalid); else passed++;
      checks++; if (s_smiso !== 16'hA5A5) $display("FAIL single_hold got %h exp a5a5", s_smiso); else passed++;
   endtask

   task automatic test_round_robin();
      logic [NP-1:0] wr; int hi; logic ts;
      logic [1:0] exp_id;
      int order [5] = '{0, 1, 2, 3, 0};
      do_reset();
      ack_delay = 0;
      for (int p = 0; p < 4; p++) set_port(p, 16'h1000 + 16'(p), 15'h0200 + 15'(p));
      @(posedge clk); #1;
      s_wvalid = 4'b1111;
      for (int t = 0; t < 5; t++) begin
         exp_id = 2'(order[t]);
         wait_resp(wr, hi, ts);
         checks++; if (wr !== (4'b0001 << exp_id) || grant !== exp_id)
            $display("FAIL rr_txn%0d got wready %b grant %0d exp port %0d", t, wr, grant, exp_id); else passed++;
         checks++; if (m_smosi !== 16'h1000 + 16'(exp_id))
            $display("FAIL rr_smosi%0d got %h exp %h", t, m_smosi, 16'h1000 + 16'(exp_id)); else passed++;
      end
      @(posedge clk); #1;
      s_wvalid = '0;
      repeat (3) @(posedge clk);
   endtask

   task automatic test_timeout();
      logic [NP-1:0] wr; int hi; logic ts;
      ack_delay = 100;
      @(posedge clk); #1;
      set_port(3, 16'h3333, 15'h0333);
      s_wvalid = 4'b1000;
      wait_resp(wr, hi, ts);
      checks++; if (hi != 8) $display("FAIL tout_busy_len got %0d exp 8", hi); else passed++;
      checks++; if (tout !== 1'b1) $display("FAIL tout_pulse got %b exp 1", tout); else passed++;
      checks++; if (s_smiso !== 16'hFFFF || s_dmiso !== 15'h0)
         $display("FAIL tout_resp got %h %h exp ffff 0000", s_smiso, s_dmiso); else passed++;
      checks++; if (wr !== 4'b1000 || grant !== 2'd3)
         $display("FAIL tout_wready got %b grant %0d exp 1000 3", wr, grant); else passed++;
      @(posedge clk); #1;
      s_wvalid = '0;
      @(negedge clk);
      checks++; if (tout !== 1'b0 || m_wvalid !== 1'b0)
         $display("FAIL tout_after got %b %b exp 0 0", tout, m_wvalid); else passed++;
   endtask

   task automatic test_terminal_ack();
      logic [NP-1:0] wr; int hi; logic ts;
      ack_delay = 7;
      slv_smiso = 16'h1234;
      slv_dmiso = 15'h0321;
      @(posedge clk); #1;
      set_port(1, 16'h0111, 15'h0011);
      s_wvalid = 4'b0010;
      wait_resp(wr, hi, ts);
      checks++; if (hi != 8) $display("FAIL term_busy_len got %0d exp 8", hi); else passed++;
      checks++; if (ts !== 1'b0) $display("FAIL term_tout got %b exp 0", ts); else passed++;
      checks++; if (s_smiso !== 16'h1234 || s_dmiso !== 15'h0321)
         $display("FAIL term_resp got %h %h exp 1234 0321", s_smiso, s_dmiso); else passed++;
      checks++; if (wr !== 4'b0010) $display("FAIL term_wready got %b exp 0010", wr); else passed++;
      @(posedge clk); #1;
      s_wvalid = '0;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_hold_data();
      logic [NP-1:0] wr; int hi; logic ts;
      ack_delay = 3;
      @(posedge clk); #1;
      set_port(1, 16'h0BEE, 15'h0456);
      s_wvalid = 4'b0010;
      @(posedge clk);
      @(negedge clk);
      checks++; if (m_smosi !== 16'h0BEE) $display("FAIL hold_latch got %h exp 0bee", m_smosi); else passed++;
      set_port(1, 16'hDEAD, 15'h7FFF);
      s_wvalid = 4'b0011;
      repeat (2) @(negedge clk);
      checks++; if (m_smosi !== 16'h0BEE || m_dmosi !== 15'h0456 || grant !== 2'd1)
         $display("FAIL hold_busy got %h %h %0d exp 0bee 0456 1", m_smosi, m_dmosi, grant); else passed++;
      wait_resp(wr, hi, ts);
      checks++; if (wr !== 4'b0010) $display("FAIL hold_wready got %b exp 0010", wr); else passed++;
      @(posedge clk); #1;
      s_wvalid = '0;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_reset_mid();
      logic [NP-1:0] wr; int hi; logic ts;
      ack_delay = 0;
      @(posedge clk); #1;
      set_port(0, 16'h00A0, 15'h00A0);
      s_wvalid = 4'b0001;
      wait_resp(wr, hi, ts);
      checks++; if (wr !== 4'b0001) $display("FAIL rmid_pre got %b exp 0001", wr); else passed++;
      @(posedge clk); #1;
      s_wvalid = '0;
      repeat (2) @(posedge clk);
      ack_delay = 100;
      #1;
      set_port(1, 16'h00B1, 15'h00B1);
      s_wvalid = 4'b0010;
      @(posedge clk);
      @(negedge clk);
      checks++; if (m_wvalid !== 1'b1) $display("FAIL rmid_busy got %b exp 1", m_wvalid); else passed++;
      #1 rst_n = 1'b0;
      #1;
      checks++; if ({m_wvalid, m_smosi, m_dmosi, grant, s_wready, tout} !== '0)
         $display("FAIL rmid_async got %b %h %h %0d %b %b exp all 0", m_wvalid, m_smosi, m_dmosi, grant, s_wready, tout); else passed++;
      s_wvalid = '0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      ack_delay = 0;
      @(posedge clk); #1;
      set_port(3, 16'h00C3, 15'h00C3);
      s_wvalid = 4'b1001;
      wait_resp(wr, hi, ts);
      checks++; if (wr !== 4'b0001 || grant !== 2'd0)
         $display("FAIL rmid_prio got %b grant %0d exp 0001 0", wr, grant); else passed++;
      checks++; if (s_smiso !== 16'h1234) $display("FAIL rmid_resp got %h exp 1234", s_smiso); else passed++;
      @(posedge clk); #1;
      s_wvalid = '0;
      repeat (2) @(posedge clk);
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_timeout();
      test_terminal_ack();
      test_hold_data();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
